// File: rtl/jpeg_idct_pkg.sv
// Shared constants for the JPEG row/column DCT pair: basis magnitudes, the 8x8
// inverse-DCT basis table and the sample/coefficient widths.
package jpeg_idct_pkg;

  localparam int COEF_W = 8;
  localparam int SAMP_W = 8;

  localparam int C1 = 63;
  localparam int C2 = 59;
  localparam int C3 = 53;
  localparam int C4 = 45;
  localparam int C5 = 36;
  localparam int C6 = 24;
  localparam int C7 = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } idct_state_e;

  // Row n = output sample index, column k = coefficient index.
  localparam logic signed [6:0] BASIS [8][8] = '{
    '{7'(C4),  7'(C1),  7'(C2),  7'(C3),  7'(C4),  7'(C5),  7'(C6),  7'(C7)},
    '{7'(C4),  7'(C3),  7'(C6), -7'(C7), -7'(C4), -7'(C1), -7'(C2), -7'(C5)},
    '{7'(C4),  7'(C5), -7'(C6), -7'(C1), -7'(C4),  7'(C7),  7'(C2),  7'(C3)},
    '{7'(C4),  7'(C7), -7'(C2), -7'(C5),  7'(C4),  7'(C3), -7'(C6), -7'(C1)},
    '{7'(C4), -7'(C7), -7'(C2),  7'(C5),  7'(C4), -7'(C3), -7'(C6),  7'(C1)},
    '{7'(C4), -7'(C5), -7'(C6),  7'(C1), -7'(C4), -7'(C7),  7'(C2), -7'(C3)},
    '{7'(C4), -7'(C3),  7'(C6),  7'(C7), -7'(C4),  7'(C1), -7'(C2),  7'(C5)},
    '{7'(C4), -7'(C1),  7'(C2), -7'(C3),  7'(C4), -7'(C5),  7'(C6), -7'(C7)}
  };

  function automatic logic signed [6:0] idct_basis(input logic [2:0] n, input logic [2:0] k);
    return BASIS[n][k];
  endfunction

endpackage

// File: rtl/idct_row_mac.sv
// Combinational kernel: one spatial sample from 8 coefficients, with the
// rounding shift and signed saturation to SAMP_W bits.
module idct_row_mac
  import jpeg_idct_pkg::*;
#(
  parameter int OUT_SHIFT = 7,
  parameter int ACC_W     = 18
) (
  input  logic [8*COEF_W-1:0] coef,
  input  logic [2:0]          n,
  output logic [SAMP_W-1:0]   y
);

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 << (OUT_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] xe;
  logic signed [ACC_W-1:0] te;
  logic signed [ACC_W-1:0] rnd_sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [6:0]       t;
  logic [COEF_W-1:0]       x;

  always_comb begin
    acc = '0;
    xe  = '0;
    te  = '0;
    t   = '0;
    x   = '0;
    for (int k = 0; k < 8; k++) begin
      x   = coef[8*COEF_W-1-COEF_W*k -: COEF_W];
      t   = idct_basis(n, k[2:0]);
      xe  = {{(ACC_W-COEF_W){x[COEF_W-1]}}, x};
      te  = {{(ACC_W-7){t[6]}}, t};
      acc = acc + xe * te;
    end
    rnd_sum = acc + RND;
    // Arithmetic shift: rounds half toward +inf after the bias is added.
    shifted = rnd_sum >>> OUT_SHIFT;
    if (shifted > SAT_HI)      y = 8'h7F;
    else if (shifted < SAT_LO) y = 8'h80;
    else                       y = shifted[SAMP_W-1:0];
  end

endmodule

// File: rtl/idct_row_inv.sv
// Inverse 8-point row IDCT: latches a coefficient row, produces one sample per
// cycle through a shared MAC, then holds the finished row until the sink takes it.
module idct_row_inv
  import jpeg_idct_pkg::*;
#(
  parameter int OUT_SHIFT = 7,
  parameter int ACC_W     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // source holds its data while valid is high and ready is low.

  idct_state_e state_q, state_d;
  logic [2:0]  n_q;
  logic [63:0] coef_q;
  logic [63:0] out_q;
  logic [7:0]  y;

  idct_row_mac #(
    .OUT_SHIFT(OUT_SHIFT),
    .ACC_W    (ACC_W)
  ) u_mac (
    .coef(coef_q),
    .n   (n_q),
    .y   (y)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (n_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      coef_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        coef_q <= in;
        n_q    <= '0;
      end
      if (state_q == ST_CALC) begin
        // out keeps the previous row until byte 0 of the new one lands here.
        for (int b = 0; b < 8; b++) begin
          if (n_q == b[2:0]) out_q[63-8*b -: 8] <= y;
        end
        n_q <= n_q + 3'd1;
      end
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_idct_row_inv.sv
// Self-checking bench for idct_row_inv: directed corner rows, backpressure,
// mid-row reset and random rows against a cosine-based reference model.
module tb_idct_row_inv;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_row;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_row;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  idct_row_inv dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_row),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out_row),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: T[n][k] = round(64 * c(k) * cos((2n+1) k pi / 16)), y = floor((S+64)/128), clamp.
  function automatic int basis(input int n, input int k);
    real c, v;
    c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 64.0 * c * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [63:0] model_row(input logic [63:0] r);
    logic [63:0] res;
    logic [7:0]  xb;
    int s, yv;
    res = '0;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) begin
        xb = r[63-8*k -: 8];
        s += int'(signed'(xb)) * basis(n, k);
      end
      yv = (s + 64) >>> 7;
      if (yv > 127) yv = 127;
      if (yv < -128) yv = -128;
      res[63-8*n -: 8] = yv[7:0];
    end
    return res;
  endfunction

  task automatic send_row(input logic [63:0] row, input bit use_exp, input logic [63:0] exp);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    in_row   = row;
    in_valid = 1'b1;
    exp_q.push_back(use_exp ? exp : model_row(row));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for the row, hold off the sink for `stall` cycles, then drain it.
  task automatic recv_row(input string tag, input int stall, input bit pulse_in);
    int guard = 0;
    logic [63:0] exp;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      check({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check(tag, out_row, exp);
    for (int i = 0; i < stall; i++) begin
      if (pulse_in) begin
        in_row   = {$urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check({tag, "_hold_out"}, out_row, exp);
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_drain_out"}, out_row, exp);
  endtask

  initial begin
    logic [63:0] held;
    rst       = 1'b1;
    in_row    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out", out_row, 64'd0);

    send_row(64'h0, 1'b1, 64'h0);
    recv_row("zeros", 0, 1'b0);
    send_row(64'h4000_0000_0000_0000, 1'b1, 64'h1717_1717_1717_1717);
    recv_row("dc_pos", 0, 1'b0);
    send_row(64'h8000_0000_0000_0000, 1'b1, 64'hD3D3_D3D3_D3D3_D3D3);
    recv_row("dc_neg", 0, 1'b0);
    send_row(64'h7F7F_7F7F_7F7F_7F7F, 1'b1, 64'h7FA4_48E5_29FD_1709);
    recv_row("all_7f", 0, 1'b0);

    // Backpressure with ignored in_valid pulses.
    send_row(64'h1234_F0E1_0280_7F05, 1'b0, 64'h0);
    recv_row("bp", 5, 1'b1);

    // in_valid and out_ready together in DONE: only the output moves.
    send_row(64'h0A0B_0C0D_F1F2_F3F4, 1'b0, 64'h0);
    begin
      int guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    check("both_valid", {63'd0, out_valid}, 64'd1);
    check("both_out", out_row, exp_q.pop_front());
    held      = 64'hC864_3210_EF01_9977;
    in_row    = held;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("both_idle_ready", {63'd0, in_ready}, 64'd1);
    check("both_idle_valid", {63'd0, out_valid}, 64'd0);
    exp_q.push_back(model_row(held));
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv_row("both_next", 0, 1'b0);

    // Reset while computing sample 3 discards the row.
    send_row(64'h7F80_7F80_7F80_7F80, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out", out_row, 64'd0);
    void'(exp_q.pop_back());
    send_row(64'h2000_1000_0800_0400, 1'b0, 64'h0);
    recv_row("post_rst", 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      send_row({$urandom, $urandom}, 1'b0, 64'h0);
      recv_row("rand", $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
